// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RISC-V opcodes, control encodings and immediate extraction
package riscv_pkg;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;

    typedef enum logic [1:0] {WB_MEM = 2'd0, WB_ALU = 2'd1, WB_PC4 = 2'd2} wb_sel_t;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
    } alu_sel_t;

    typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_type_t;

    function automatic logic [31:0] gen_imm(input logic [31:0] i, input imm_type_t t);
        case (t)
            IMM_I:   return {{20{i[31]}}, i[31:20]};
            IMM_S:   return {{20{i[31]}}, i[31:25], i[11:7]};
            IMM_B:   return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            IMM_U:   return {i[31:12], 12'b0};
            IMM_J:   return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: return '0;
        endcase
    endfunction
endpackage

// File: rtl/id_regfile.sv
// id_regfile: 2-read/1-write register file, x0 hardwired to zero, optional write-back bypass
module id_regfile #(
    parameter int XLEN      = 32,
    parameter int NREG      = 32,
    parameter int WB_BYPASS = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [4:0]      ra_addr,
    input  logic [4:0]      rb_addr,
    output logic [XLEN-1:0] ra_data,
    output logic [XLEN-1:0] rb_data,
    input  logic            we,
    input  logic [4:0]      wa,
    input  logic [XLEN-1:0] wd
);
    localparam int AW = $clog2(NREG);
    localparam logic [4:0] HI = 5'(~(NREG - 1));
    localparam bit BYP = WB_BYPASS != 0;

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic            wr;

    // addresses with bits above the implemented range are treated as nonexistent
    assign wr = we && wa != '0 && (wa & HI) == '0;

    always_comb begin
        regs_d = regs_q;
        if (wr) regs_d[wa[AW-1:0]] = wd;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) regs_q <= '{default: '0};
        else          regs_q <= regs_d;
    end

    assign ra_data = (ra_addr == '0 || (ra_addr & HI) != '0) ? '0 :
                     (BYP && wr && wa == ra_addr) ? wd : regs_q[ra_addr[AW-1:0]];
    assign rb_data = (rb_addr == '0 || (rb_addr & HI) != '0) ? '0 :
                     (BYP && wr && wa == rb_addr) ? wd : regs_q[rb_addr[AW-1:0]];
endmodule

// File: rtl/id_stage_hz.sv
// id_stage_hz: RISC-V decode stage with regfile, load-use stall, flush and ID/EX register
module id_stage_hz import riscv_pkg::*; #(
    parameter int XLEN      = 32,
    parameter int NREG      = 32,
    parameter int WB_BYPASS = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            if_valid,
    input  logic [XLEN-1:0] pc,
    input  logic [31:0]     instruction,
    input  logic            flush,
    input  logic            wb_we,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic            id_stall,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_data_a,
    output logic [XLEN-1:0] ex_data_b,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_addr_d,
    output logic [4:0]      ex_addr_a,
    output logic [4:0]      ex_addr_b,
    output logic [3:0]      ex_alu_sel,
    output logic [2:0]      ex_funct3,
    output logic [1:0]      ex_wb_sel,
    output logic            ex_reg_wen,
    output logic            ex_mem_rw,
    output logic            ex_a_sel,
    output logic            ex_b_sel,
    output logic            ex_is_branch,
    output logic            ex_is_jump,
    output logic            ex_illegal
);
    localparam logic [4:0] HI = 5'(~(NREG - 1));

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] data_a;
        logic [XLEN-1:0] data_b;
        logic [XLEN-1:0] imm;
        logic [4:0]      addr_d;
        logic [4:0]      addr_a;
        logic [4:0]      addr_b;
        alu_sel_t        alu_sel;
        logic [2:0]      funct3;
        wb_sel_t         wb_sel;
        logic            reg_wen;
        logic            mem_rw;
        logic            a_sel;
        logic            b_sel;
        logic            is_branch;
        logic            is_jump;
        logic            illegal;
    } idex_t;

    idex_t           dec, ex_d, ex_q;
    logic [6:0]      opcode;
    logic [4:0]      rd, rs1, rs2;
    logic [XLEN-1:0] rs1_data, rs2_data;
    logic            use_rs1, use_rs2, hazard;
    imm_type_t       imm_type;
    alu_sel_t        alu_f3;

    assign opcode = instruction[6:0];
    assign rd     = instruction[11:7];
    assign rs1    = instruction[19:15];
    assign rs2    = instruction[24:20];

    id_regfile #(.XLEN(XLEN), .NREG(NREG), .WB_BYPASS(WB_BYPASS)) u_rf (
        .clk(clk), .reset_n(reset_n),
        .ra_addr(rs1), .rb_addr(rs2), .ra_data(rs1_data), .rb_data(rs2_data),
        .we(wb_we), .wa(wb_addr), .wd(wb_data)
    );

    always_comb begin
        alu_f3 = ALU_ADD;
        case (instruction[14:12])
            3'd0:    alu_f3 = (opcode == OP && instruction[30]) ? ALU_SUB : ALU_ADD;
            3'd1:    alu_f3 = ALU_SLL;
            3'd2:    alu_f3 = ALU_SLT;
            3'd3:    alu_f3 = ALU_SLTU;
            3'd4:    alu_f3 = ALU_XOR;
            3'd5:    alu_f3 = instruction[30] ? ALU_SRA : ALU_SRL;
            3'd6:    alu_f3 = ALU_OR;
            default: alu_f3 = ALU_AND;
        endcase
    end

    always_comb begin
        dec          = '0;
        dec.valid    = 1'b1;
        dec.pc       = pc;
        dec.data_a   = rs1_data;
        dec.data_b   = rs2_data;
        dec.addr_d   = rd;
        dec.addr_a   = rs1;
        dec.addr_b   = rs2;
        dec.funct3   = instruction[14:12];
        imm_type     = IMM_NONE;
        use_rs1      = 1'b0;
        use_rs2      = 1'b0;
        case (opcode)
            OP:     begin dec.alu_sel = alu_f3; dec.wb_sel = WB_ALU; dec.reg_wen = 1'b1;
                          use_rs1 = 1'b1; use_rs2 = 1'b1; end
            OP_IMM: begin dec.alu_sel = alu_f3; dec.wb_sel = WB_ALU; dec.reg_wen = 1'b1;
                          dec.b_sel = 1'b1; use_rs1 = 1'b1; imm_type = IMM_I; end
            LOAD:   begin dec.wb_sel = WB_MEM; dec.reg_wen = 1'b1; dec.b_sel = 1'b1;
                          use_rs1 = 1'b1; imm_type = IMM_I; end
            STORE:  begin dec.mem_rw = 1'b1; dec.b_sel = 1'b1;
                          use_rs1 = 1'b1; use_rs2 = 1'b1; imm_type = IMM_S; end
            BRANCH: begin dec.is_branch = 1'b1; dec.a_sel = 1'b1; dec.b_sel = 1'b1;
                          use_rs1 = 1'b1; use_rs2 = 1'b1; imm_type = IMM_B; end
            JAL:    begin dec.wb_sel = WB_PC4; dec.reg_wen = 1'b1; dec.is_jump = 1'b1;
                          dec.a_sel = 1'b1; dec.b_sel = 1'b1; imm_type = IMM_J; end
            JALR:   begin dec.wb_sel = WB_PC4; dec.reg_wen = 1'b1; dec.is_jump = 1'b1;
                          dec.b_sel = 1'b1; use_rs1 = 1'b1; imm_type = IMM_I; end
            LUI:    begin dec.alu_sel = ALU_PASS_B; dec.wb_sel = WB_ALU; dec.reg_wen = 1'b1;
                          dec.b_sel = 1'b1; imm_type = IMM_U; end
            AUIPC:  begin dec.wb_sel = WB_ALU; dec.reg_wen = 1'b1; dec.a_sel = 1'b1;
                          dec.b_sel = 1'b1; imm_type = IMM_U; end
            default: dec.illegal = 1'b1;
        endcase
        dec.imm = XLEN'($signed(gen_imm(instruction, imm_type)));
        // RV32E: any referenced register beyond NREG makes the instruction illegal
        if ((use_rs1 && (rs1 & HI) != '0) || (use_rs2 && (rs2 & HI) != '0) ||
            (dec.reg_wen && (rd & HI) != '0)) begin
            dec.illegal = 1'b1;
            dec.reg_wen = 1'b0;
            dec.mem_rw  = 1'b0;
        end
    end

    assign hazard = ex_q.valid && ex_q.wb_sel == WB_MEM && ex_q.reg_wen && ex_q.addr_d != '0 &&
                    ((use_rs1 && rs1 == ex_q.addr_d) || (use_rs2 && rs2 == ex_q.addr_d)) &&
                    if_valid && !flush;

    always_comb ex_d = (if_valid && !flush && !hazard) ? dec : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ex_q <= '0;
        else          ex_q <= ex_d;
    end

    assign id_stall     = hazard;
    assign ex_valid     = ex_q.valid;
    assign ex_pc        = ex_q.pc;
    assign ex_data_a    = ex_q.data_a;
    assign ex_data_b    = ex_q.data_b;
    assign ex_imm       = ex_q.imm;
    assign ex_addr_d    = ex_q.addr_d;
    assign ex_addr_a    = ex_q.addr_a;
    assign ex_addr_b    = ex_q.addr_b;
    assign ex_alu_sel   = ex_q.alu_sel;
    assign ex_funct3    = ex_q.funct3;
    assign ex_wb_sel    = ex_q.wb_sel;
    assign ex_reg_wen   = ex_q.reg_wen;
    assign ex_mem_rw    = ex_q.mem_rw;
    assign ex_a_sel     = ex_q.a_sel;
    assign ex_b_sel     = ex_q.b_sel;
    assign ex_is_branch = ex_q.is_branch;
    assign ex_is_jump   = ex_q.is_jump;
    assign ex_illegal   = ex_q.illegal;
endmodule

// File: tb/tb_id_stage_hz.sv
// tb_id_stage_hz: RV32I and RV32E decode stages driven side by side against a reference model
module tb_id_stage_hz;
    import riscv_pkg::*;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc, a, b, imm;
        logic [4:0]  ad, aa, ab;
        logic [3:0]  alu;
        logic [2:0]  f3;
        logic [1:0]  wb;
        logic        wen, mem, asel, bsel, br, jmp, ill;
    } exp_t;

    logic        clk = 1'b0, reset_n = 1'b0, if_valid = 1'b0, flush = 1'b0, wb_we = 1'b0;
    logic [31:0] pc = '0, instruction = '0, wb_data = '0, ins;
    logic [4:0]  wb_addr = '0;
    exp_t        obs [2];
    logic        stall [2];
    exp_t        prev [2];
    logic [31:0] regs [2][32];
    logic        last_stall, obs_stall;
    int          errors = 0, checks = 0, k;
    logic [6:0]  ops [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h67, 7'h37, 7'h17, 7'h0b};

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic        v, wen, mem, asel, bsel, br, jmp, ill, stl;
        logic [31:0] epc, da, db, imm;
        logic [4:0]  ad, aa, ab;
        logic [3:0]  alu;
        logic [2:0]  f3;
        logic [1:0]  wb;
        id_stage_hz #(.XLEN(32), .NREG(g ? 16 : 32), .WB_BYPASS(1)) dut (
            .clk(clk), .reset_n(reset_n), .if_valid(if_valid), .pc(pc), .instruction(instruction),
            .flush(flush), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
            .id_stall(stl), .ex_valid(v), .ex_pc(epc), .ex_data_a(da), .ex_data_b(db), .ex_imm(imm),
            .ex_addr_d(ad), .ex_addr_a(aa), .ex_addr_b(ab), .ex_alu_sel(alu), .ex_funct3(f3),
            .ex_wb_sel(wb), .ex_reg_wen(wen), .ex_mem_rw(mem), .ex_a_sel(asel), .ex_b_sel(bsel),
            .ex_is_branch(br), .ex_is_jump(jmp), .ex_illegal(ill)
        );
        assign obs[g]   = {v, epc, da, db, imm, ad, aa, ab, alu, f3, wb, wen, mem, asel, bsel, br, jmp, ill};
        assign stall[g] = stl;
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic use1(input logic [31:0] i);
        return i[6:0] inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67};
    endfunction

    function automatic logic use2(input logic [31:0] i);
        return i[6:0] inside {7'h33, 7'h23, 7'h63};
    endfunction

    function automatic logic [31:0] rf(input int g, input logic [4:0] r);
        if (r == 0 || r >= (g ? 16 : 32)) return '0;
        return (wb_we && wb_addr == r) ? wb_data : regs[g][r];
    endfunction

    function automatic logic hazard(input exp_t p);
        return p.valid && p.wb == 2'd0 && p.wen && p.ad != 0 &&
               ((use1(instruction) && instruction[19:15] == p.ad) ||
                (use2(instruction) && instruction[24:20] == p.ad)) && if_valid && !flush;
    endfunction

    function automatic logic [3:0] alu_of(input logic [31:0] i, input logic is_op);
        case (i[14:12])
            3'd0: return (is_op && i[30]) ? ALU_SUB : ALU_ADD;
            3'd1: return ALU_SLL;
            3'd2: return ALU_SLT;
            3'd3: return ALU_SLTU;
            3'd4: return ALU_XOR;
            3'd5: return i[30] ? ALU_SRA : ALU_SRL;
            3'd6: return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic exp_t decode(input int nreg, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   s;
        logic [31:0] i;
        i = instruction;
        s = $signed(i);
        e = '0;
        e.valid = 1'b1; e.pc = pc; e.a = a; e.b = b;
        e.ad = i[11:7]; e.aa = i[19:15]; e.ab = i[24:20]; e.f3 = i[14:12]; e.alu = ALU_ADD;
        case (i[6:0])
            7'h33: begin e.wb = 2'd1; e.wen = 1; e.alu = alu_of(i, 1'b1); end
            7'h13: begin e.wb = 2'd1; e.wen = 1; e.bsel = 1; e.imm = s >>> 20; e.alu = alu_of(i, 1'b0); end
            7'h03: begin e.wb = 2'd0; e.wen = 1; e.bsel = 1; e.imm = s >>> 20; end
            7'h23: begin e.mem = 1; e.bsel = 1; e.imm = ((s >>> 25) <<< 5) + int'(i[11:7]); end
            7'h63: begin e.br = 1; e.asel = 1; e.bsel = 1;
                         e.imm = (i[31] ? -4096 : 0) + (int'(i[7]) << 11) + (int'(i[30:25]) << 5) + (int'(i[11:8]) << 1); end
            7'h6f: begin e.wb = 2'd2; e.wen = 1; e.jmp = 1; e.asel = 1; e.bsel = 1;
                         e.imm = (i[31] ? -(1 << 20) : 0) + (int'(i[19:12]) << 12) + (int'(i[20]) << 11) + (int'(i[30:21]) << 1); end
            7'h67: begin e.wb = 2'd2; e.wen = 1; e.jmp = 1; e.bsel = 1; e.imm = s >>> 20; end
            7'h37: begin e.wb = 2'd1; e.wen = 1; e.bsel = 1; e.imm = i & 32'hFFFFF000; e.alu = ALU_PASS_B; end
            7'h17: begin e.wb = 2'd1; e.wen = 1; e.asel = 1; e.bsel = 1; e.imm = i & 32'hFFFFF000; end
            default: e.ill = 1;
        endcase
        if ((use1(i) && i[19:15] >= nreg) || (use2(i) && i[24:20] >= nreg) || (e.wen && i[11:7] >= nreg)) begin
            e.ill = 1; e.wen = 0; e.mem = 0;
        end
        return e;
    endfunction

    task automatic drive(input logic v, input logic [31:0] i, input logic fl,
                         input logic we, input logic [4:0] wa, input logic [31:0] wd);
        if_valid = v; instruction = i; flush = fl; wb_we = we; wb_addr = wa; wb_data = wd; pc = pc + 4;
    endtask

    task automatic step(input string tag);
        exp_t e [2];
        logic hz;
        #1;
        obs_stall = stall[0];
        for (int g = 0; g < 2; g++) begin
            hz = hazard(prev[g]);
            if (g == 0) last_stall = hz;
            check($sformatf("%s stall n%0d", tag, g ? 16 : 32), 256'(stall[g]), 256'(hz));
            e[g] = (!if_valid || flush || hz) ? '0 : decode(g ? 16 : 32, rf(g, instruction[19:15]), rf(g, instruction[24:20]));
        end
        @(posedge clk);
        #1;
        for (int g = 0; g < 2; g++) begin
            check($sformatf("%s ex n%0d", tag, g ? 16 : 32), 256'(obs[g]), 256'(e[g]));
            prev[g] = e[g];
            if (wb_we && wb_addr != 0 && wb_addr < (g ? 16 : 32)) regs[g][wb_addr] = wb_data;
        end
        @(negedge clk);
    endtask

    function automatic logic [31:0] r_t(input int rs2, input int rs1, input int rd);
        return {7'd0, 5'(rs2), 5'(rs1), 3'd0, 5'(rd), 7'h33};
    endfunction

    function automatic logic [31:0] i_t(input int imm, input int rs1, input int f3, input int rd, input logic [6:0] op);
        return {12'(imm), 5'(rs1), 3'(f3), 5'(rd), op};
    endfunction

    initial begin
        for (int g = 0; g < 2; g++) begin
            prev[g] = '0;
            for (int r = 0; r < 32; r++) regs[g][r] = '0;
        end
        drive(1, r_t(1, 3, 4), 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        #1;
        check("reset ex32", 256'(obs[0]), 256'(0));
        check("reset ex16", 256'(obs[1]), 256'(0));
        check("reset stall", 256'(stall[0]), 256'(0));
        reset_n = 1'b1;
        @(negedge clk);

        drive(0, 0, 0, 1, 5, 32'h0000_1234);
        step("wb x5");
        drive(1, r_t(0, 5, 6), 0, 0, 0, 0);
        step("add x6");
        check("add valid", 256'(obs[0].valid), 256'(1));
        check("add data_a", 256'(obs[0].a), 256'(32'h1234));
        check("add data_b", 256'(obs[0].b), 256'(0));
        check("add rd", 256'(obs[0].ad), 256'(6));
        check("add wb_sel", 256'(obs[0].wb), 256'(1));

        drive(1, {7'd0, 5'd7, 5'd1, 3'd2, 5'd8, 7'h23}, 0, 1, 7, 32'hDEAD_BEEF);
        step("sw bypass");
        check("sw data_b", 256'(obs[0].b), 256'(32'hDEAD_BEEF));
        check("sw imm", 256'(obs[0].imm), 256'(8));
        check("sw mem_rw", 256'(obs[0].mem), 256'(1));
        check("sw reg_wen", 256'(obs[0].wen), 256'(0));

        drive(1, i_t(0, 2, 2, 3, 7'h03), 0, 0, 0, 0);
        step("lw x3");
        drive(1, r_t(1, 3, 4), 0, 0, 0, 0);
        step("lu stall");
        check("lu stall on", 256'(obs_stall), 256'(1));
        check("lu bubble", 256'(obs[0].valid), 256'(0));
        step("lu release");
        check("lu stall off", 256'(obs_stall), 256'(0));
        check("lu add valid", 256'(obs[0].valid), 256'(1));
        check("lu add rs1", 256'(obs[0].aa), 256'(3));

        drive(1, i_t(0, 2, 2, 0, 7'h03), 0, 0, 0, 0);
        step("lw x0");
        drive(1, r_t(1, 0, 4), 0, 0, 0, 0);
        step("add after lw x0");
        check("x0 no stall", 256'(obs_stall), 256'(0));
        drive(1, i_t(0, 2, 2, 3, 7'h03), 0, 0, 0, 0);
        step("lw x3 b");
        drive(1, {20'h12345, 5'd3, 7'h37}, 0, 0, 0, 0);
        step("lui after lw");
        check("lui no stall", 256'(obs_stall), 256'(0));

        drive(1, i_t(0, 2, 2, 3, 7'h03), 0, 0, 0, 0);
        step("lw x3 c");
        drive(1, r_t(1, 3, 4), 1, 0, 0, 0);
        step("hazard+flush");
        check("flush no stall", 256'(obs_stall), 256'(0));
        check("flush bubble", 256'(obs[0].valid), 256'(0));
        drive(0, 0, 0, 1, 0, 5);
        step("wb x0");
        drive(1, r_t(0, 0, 1), 0, 1, 0, 5);
        step("read x0");
        check("x0 reads 0", 256'(obs[0].a), 256'(0));

        drive(1, i_t(1, 1, 0, 20, 7'h13), 0, 0, 0, 0);
        step("addi x20");
        check("rv32e illegal", 256'(obs[1].ill), 256'(1));
        check("rv32e reg_wen", 256'(obs[1].wen), 256'(0));
        check("rv32i legal", 256'(obs[0].ill), 256'(0));

        for (int n = 0; n < 400; n++) begin
            if (!last_stall) begin
                k = $urandom_range(0, 11);
                ins = $urandom;
                ins[6:0] = k >= 10 ? 7'h03 : ops[k];
                if ($urandom_range(0, 3) != 0) begin
                    ins[11:7]  = 5'($urandom_range(0, 7));
                    ins[19:15] = 5'($urandom_range(0, 7));
                    ins[24:20] = 5'($urandom_range(0, 7));
                end
                instruction = ins;
                pc = $urandom & ~32'h3;
                if_valid = $urandom_range(0, 7) != 0;
            end
            flush   = $urandom_range(0, 9) == 0;
            wb_we   = 1'($urandom_range(0, 1));
            wb_addr = 5'($urandom_range(0, 31));
            wb_data = $urandom;
            step("rand");
        end

        drive(0, 0, 0, 0, 0, 0);
        step("idle");
        drive(1, i_t(0, 2, 2, 3, 7'h03), 0, 0, 0, 0);
        step("lw x3 d");
        drive(1, r_t(1, 3, 4), 0, 0, 0, 0);
        #1;
        check("pre-reset stall32", 256'(stall[0]), 256'(1));
        check("pre-reset stall16", 256'(stall[1]), 256'(1));
        #2 reset_n = 1'b0;
        #1;
        check("mid-stall reset ex32", 256'(obs[0]), 256'(0));
        check("mid-stall reset ex16", 256'(obs[1]), 256'(0));
        check("mid-stall reset stall", 256'(stall[0]), 256'(0));
        @(posedge clk);
        #1;
        check("reset held ex32", 256'(obs[0]), 256'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
